descrambler: RTL and testbench

Receive-side counterpart of the PHY transmit scrambler, one instance per lane between the RX lane-deskew/block-alignment logic and the PIPE RX data interface. It removes the Gen1/Gen2 8b/10b scrambling (16-bit LFSR, reset by COM) or the Gen3+ 128b/130b scrambling (23-bit LFSR, per-lane seed, reset by EIEOS). It tracks symbol and block position itself. Output is registered, with fixed one-cycle latency.

---
 rtl/pcie_phy_pkg.sv | 34 +++
 rtl/descrambler_lfsr_byte.sv | 27 ++
 rtl/descrambler.sv | 172 +++++++++++++++++
 tb/tb_descrambler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_phy_pkg.sv
// Shared PHY constants: scrambler polynomials, special symbol codes, sync headers
// and the Gen3 descrambler block-tracking state encoding.
package pcie_phy_pkg;

    // Galois feedback masks: bits that receive the LFSR MSB on every shift
    localparam logic [15:0] G12_POLY_TAPS = 16'h0039;   // X^16+X^5+X^4+X^3+1
    localparam logic [22:0] G3_POLY_TAPS  = 23'h210125; // X^23+X^21+X^16+X^8+X^5+X^2+1
    localparam logic [15:0] G12_SEED      = 16'hFFFF;

    localparam logic [7:0] K_COM       = 8'hBC;
    localparam logic [7:0] K_SKP       = 8'h1C;
    localparam logic [7:0] OS_SKP_ID   = 8'hAA;
    localparam logic [7:0] OS_EIEOS_ID = 8'h00;

    localparam logic [1:0] SYNC_HDR_DATA = 2'b01;
    localparam logic [1:0] SYNC_HDR_OS   = 2'b10;

    typedef enum logic [2:0] {
        SEED_LOAD = 3'd0,
        SYNC_WAIT = 3'd1,
        DATA_BLK  = 3'd2,
        OS_BLK    = 3'd3,
        SKP_BLK   = 3'd4
    } g3_state_e;

    function automatic logic [15:0] g12_step(input logic [15:0] s);
        return {s[14:0], 1'b0} ^ (s[15] ? G12_POLY_TAPS : 16'h0000);
    endfunction

    function automatic logic [22:0] g3_step(input logic [22:0] s);
        return {s[21:0], 1'b0} ^ (s[22] ? G3_POLY_TAPS : 23'h000000);
    endfunction

endpackage

// File: rtl/descrambler_lfsr_byte.sv
// One byte-step of either scrambler LFSR: produces the 8 keystream bits
// (LSB first on the wire) and the state after 8 shifts.
module descrambler_lfsr_byte
    import pcie_phy_pkg::*;
(
    input  logic        gen3_mode,
    input  logic [22:0] lfsr_in,
    output logic [22:0] lfsr_next,
    output logic [7:0]  scr_byte
);

    logic [15:0] s16;
    logic [22:0] s23;

    always_comb begin
        s16      = lfsr_in[15:0];
        s23      = lfsr_in;
        scr_byte = '0;
        for (int b = 0; b < 8; b++) begin
            scr_byte[b] = gen3_mode ? s23[22] : s16[15];
            s16 = g12_step(s16);
            s23 = g3_step(s23);
        end
        lfsr_next = gen3_mode ? s23 : {7'd0, s16};
    end

endmodule

// File: rtl/descrambler.sv
// Per-lane RX descrambler for 8b/10b (Gen1/2) and 128b/130b (Gen3+) links.
// Byte-serial LFSR chain evaluated combinationally, one registered output stage.
module descrambler
    import pcie_phy_pkg::*;
#(
    parameter logic [15:0] G12_RESET_VALUE = G12_SEED,
    parameter logic [7:0]  COM_SYMBOL      = K_COM,
    parameter logic [7:0]  SKP_SYMBOL      = K_SKP,
    parameter logic [7:0]  SKP_OS_ID       = OS_SKP_ID,
    parameter logic [7:0]  EIEOS_ID        = OS_EIEOS_ID
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [2:0]  GEN,
    input  logic [5:0]  PIPEWIDTH,
    input  logic [23:0] seedValue,
    input  logic [31:0] rxData,
    input  logic [3:0]  rxDataK,
    input  logic        rxDataValid,
    input  logic [1:0]  rxSyncHeader,
    input  logic        rxStartBlock,
    output logic [31:0] descramblerDataOut,
    output logic [3:0]  descramblerDataK,
    output logic        descramblerDataValid,
    output logic [1:0]  descramblerSyncHeader,
    output logic        descramblerStartBlock,
    output logic        blockError
);

    logic        gen3;
    logic [2:0]  nbytes;
    logic [15:0] g12_lfsr;
    logic [22:0] g3_lfsr;
    logic [22:0] chain0;
    g3_state_e   state, eff_state, state_nxt;
    logic [3:0]  sym_cnt, eff_cnt, cnt_nxt;
    logic [4:0]  cnt_sum;
    logic        is_eieos, eff_eieos;
    logic        start_ok, hdr_bad, in_blk, blk_err, blk_end;
    logic [31:0] data_c;
    logic        unused_seed_msb;

    logic [31:0] data_p1;
    logic [3:0]  k_p1;
    logic        vld_p1;
    logic [1:0]  hdr_p1;
    logic        sb_p1;
    logic        err_p1;

    assign unused_seed_msb = seedValue[23];
    assign gen3            = GEN >= 3'd3;

    always_comb begin
        case (PIPEWIDTH)
            6'd16:   nbytes = 3'd2;
            6'd32:   nbytes = 3'd4;
            default: nbytes = 3'd1;
        endcase
    end

    // A start in the middle of a block is flagged but still restarts; the
    // block state and counter seen by this cycle's bytes already reflect it.
    always_comb begin
        in_blk    = state inside {DATA_BLK, OS_BLK, SKP_BLK};
        hdr_bad   = (rxSyncHeader != SYNC_HDR_DATA) && (rxSyncHeader != SYNC_HDR_OS);
        start_ok  = gen3 && rxDataValid && rxStartBlock && (state != SEED_LOAD);
        blk_err   = start_ok && (hdr_bad || in_blk);
        eff_state = state;
        eff_cnt   = sym_cnt;
        eff_eieos = is_eieos;
        if (start_ok) begin
            eff_cnt   = '0;
            eff_eieos = rxData[7:0] == EIEOS_ID;
            if (hdr_bad)
                eff_state = SYNC_WAIT;
            else if (rxSyncHeader == SYNC_HDR_DATA)
                eff_state = DATA_BLK;
            else if (rxData[7:0] == SKP_OS_ID)
                eff_state = SKP_BLK;
            else
                eff_state = OS_BLK;
        end
        cnt_sum   = {1'b0, eff_cnt} + {2'b00, nbytes};
        blk_end   = cnt_sum >= 5'd16;
        state_nxt = SYNC_WAIT;
        cnt_nxt   = '0;
        if ((eff_state inside {DATA_BLK, OS_BLK, SKP_BLK}) && !blk_end) begin
            state_nxt = eff_state;
            cnt_nxt   = cnt_sum[3:0];
        end
    end

    assign chain0 = gen3 ? g3_lfsr : {7'd0, g12_lfsr};

    for (genvar i = 0; i < 4; i++) begin : g_byte
        logic [7:0]  din, scr;
        logic [22:0] st_in, st_adv, st_out;
        logic        active, is_com, is_skp, adv, xr;

        if (i == 0) begin : g_first
            assign st_in = chain0;
        end else begin : g_next
            assign st_in = g_byte[i-1].st_out;
        end

        descrambler_lfsr_byte u_step (
            .gen3_mode (gen3),
            .lfsr_in   (st_in),
            .lfsr_next (st_adv),
            .scr_byte  (scr)
        );

        assign din    = rxData[8*i +: 8];
        assign active = 3'(i) < nbytes;
        assign is_com = !gen3 && active && rxDataK[i] && (din == COM_SYMBOL);
        assign is_skp = !gen3 && active && rxDataK[i] && (din == SKP_SYMBOL);
        assign adv    = active && (gen3 ? (eff_state inside {DATA_BLK, OS_BLK}) : (!is_com && !is_skp));
        assign xr     = active && (gen3 ? (eff_state == DATA_BLK) : !rxDataK[i]);
        assign st_out = is_com ? {7'd0, G12_RESET_VALUE} : (adv ? st_adv : st_in);
        assign data_c[8*i +: 8] = !active ? 8'h00 : (xr ? (din ^ scr) : din);
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            g12_lfsr <= G12_RESET_VALUE;
            g3_lfsr  <= '0;
            state    <= SEED_LOAD;
            sym_cnt  <= '0;
            is_eieos <= 1'b0;
        end else begin
            if (state == SEED_LOAD) begin
                g3_lfsr <= seedValue[22:0];
                state   <= SYNC_WAIT;
            end else if (gen3 && rxDataValid) begin
                state    <= state_nxt;
                sym_cnt  <= cnt_nxt;
                is_eieos <= eff_eieos;
                g3_lfsr  <= (blk_end && (eff_state == OS_BLK) && eff_eieos) ?
                            seedValue[22:0] : g_byte[3].st_out;
            end
            if (!gen3 && rxDataValid)
                g12_lfsr <= g_byte[3].st_out[15:0];
        end
    end

    // p0 -> p1: registered output stage
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            data_p1 <= '0;
            k_p1    <= '0;
            vld_p1  <= 1'b0;
            hdr_p1  <= '0;
            sb_p1   <= 1'b0;
            err_p1  <= 1'b0;
        end else begin
            data_p1 <= rxDataValid ? data_c : '0;
            k_p1    <= rxDataK;
            vld_p1  <= rxDataValid;
            hdr_p1  <= rxSyncHeader;
            sb_p1   <= rxStartBlock;
            err_p1  <= blk_err;
        end
    end

    assign descramblerDataOut    = data_p1;
    assign descramblerDataK      = k_p1;
    assign descramblerDataValid  = vld_p1;
    assign descramblerSyncHeader = hdr_p1;
    assign descramblerStartBlock = sb_p1;
    assign blockError            = err_p1;

endmodule

// File: tb/tb_descrambler.sv
// Directed bench for descrambler: Gen1 keystream vectors, Gen3 loopback of a
// reference transmit scrambler, EIEOS reseed, block errors and async reset.
module tb_descrambler;

    logic        pclk = 1'b0;
    logic        reset;
    logic [2:0]  GEN;
    logic [5:0]  PIPEWIDTH;
    logic [23:0] seedValue;
    logic [31:0] rxData;
    logic [3:0]  rxDataK;
    logic        rxDataValid;
    logic [1:0]  rxSyncHeader;
    logic        rxStartBlock;
    logic [31:0] descramblerDataOut;
    logic [3:0]  descramblerDataK;
    logic        descramblerDataValid;
    logic [1:0]  descramblerSyncHeader;
    logic        descramblerStartBlock;
    logic        blockError;

    int checks = 0;
    int errors = 0;

    localparam logic [22:0] SEED = 23'h1DBFBC;
    logic [22:0] model;

    always #5 pclk = ~pclk;

    descrambler dut (
        .pclk                  (pclk),
        .reset                 (reset),
        .GEN                   (GEN),
        .PIPEWIDTH             (PIPEWIDTH),
        .seedValue             (seedValue),
        .rxData                (rxData),
        .rxDataK               (rxDataK),
        .rxDataValid           (rxDataValid),
        .rxSyncHeader          (rxSyncHeader),
        .rxStartBlock          (rxStartBlock),
        .descramblerDataOut    (descramblerDataOut),
        .descramblerDataK      (descramblerDataK),
        .descramblerDataValid  (descramblerDataValid),
        .descramblerSyncHeader (descramblerSyncHeader),
        .descramblerStartBlock (descramblerStartBlock),
        .blockError            (blockError)
    );

    // Bit-serial Gen3 transmit scrambler: next 4 keystream bytes, byte 0 LSB first
    function automatic logic [31:0] next_ks();
        logic [31:0] w;
        logic        fb;
        w = '0;
        for (int b = 0; b < 32; b++) begin
            fb    = model[22];
            w[b]  = fb;
            model = {model[21:0], fb};
            model[2]  = model[2]  ^ fb;
            model[5]  = model[5]  ^ fb;
            model[8]  = model[8]  ^ fb;
            model[16] = model[16] ^ fb;
            model[21] = model[21] ^ fb;
        end
        return w;
    endfunction

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] k,
                         input logic [1:0] h, input logic sb);
        rxDataValid  = v;
        rxData       = d;
        rxDataK      = k;
        rxSyncHeader = h;
        rxStartBlock = sb;
        @(posedge pclk);
        #1;
    endtask

    task automatic apply_reset(input logic [2:0] gen, input logic [5:0] pw);
        reset       = 1'b1;
        GEN         = gen;
        PIPEWIDTH   = pw;
        seedValue   = {1'b0, SEED};
        rxData      = '0;
        rxDataK     = '0;
        rxDataValid = 1'b0;
        rxSyncHeader = '0;
        rxStartBlock = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        GEN = 3'd1; PIPEWIDTH = 6'd8; seedValue = {1'b0, SEED};
        rxData = 32'hFFFFFFFF; rxDataK = 4'hF; rxDataValid = 1'b1;
        rxSyncHeader = 2'b11; rxStartBlock = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        checks++;
        if (descramblerDataOut !== 32'h0 || descramblerDataK !== 4'h0) begin
            errors++;
            $display("FAIL reset_data: got data %h k %h, expected 0/0", descramblerDataOut, descramblerDataK);
        end
        checks++;
        if ({descramblerDataValid, descramblerSyncHeader, descramblerStartBlock, blockError} !== 5'b0) begin
            errors++;
            $display("FAIL reset_side: got vld %b hdr %b sb %b err %b, expected all 0",
                     descramblerDataValid, descramblerSyncHeader, descramblerStartBlock, blockError);
        end
    endtask

    task automatic test_g12_w8;
        logic [7:0] exp_b [0:3];
        exp_b[0] = 8'hFF; exp_b[1] = 8'h17; exp_b[2] = 8'hC0; exp_b[3] = 8'h14;
        apply_reset(3'd1, 6'd8);
        drive(1'b1, 32'h000000BC, 4'b0001, 2'b00, 1'b0);
        checks++;
        if (descramblerDataOut !== 32'h000000BC || descramblerDataK !== 4'b0001 || descramblerDataValid !== 1'b1) begin
            errors++;
            $display("FAIL g12w8_com: got %h k %b vld %b, expected 000000bc k 0001 vld 1",
                     descramblerDataOut, descramblerDataK, descramblerDataValid);
        end
        for (int n = 0; n < 4; n++) begin
            drive(1'b1, 32'hAABBCC00, 4'b0000, 2'b00, 1'b0);
            checks++;
            if (descramblerDataOut !== {24'h0, exp_b[n]} || descramblerDataK !== 4'b0000) begin
                errors++;
                $display("FAIL g12w8_d%0d: got %h k %b, expected %h k 0000",
                         n, descramblerDataOut, descramblerDataK, {24'h0, exp_b[n]});
            end
        end
    endtask

    task automatic test_g12_w32;
        apply_reset(3'd1, 6'd32);
        drive(1'b1, 32'h001C1CBC, 4'b0111, 2'b00, 1'b0);
        checks++;
        if (descramblerDataOut !== 32'hFF1C1CBC || descramblerDataK !== 4'b0111) begin
            errors++;
            $display("FAIL g12w32_w0: got %h k %b, expected ff1c1cbc k 0111", descramblerDataOut, descramblerDataK);
        end
        drive(1'b1, 32'h00000000, 4'b0000, 2'b00, 1'b0);
        checks++;
        if (descramblerDataOut !== 32'hB214C017) begin
            errors++;
            $display("FAIL g12w32_w1: got %h, expected b214c017", descramblerDataOut);
        end
    endtask

    task automatic data_block(input string name, input logic expect_err0);
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, next_ks(), 4'h0, 2'b01, c == 0);
            checks++;
            if (descramblerDataOut !== 32'h0 || descramblerStartBlock !== (c == 0) ||
                descramblerSyncHeader !== 2'b01 || blockError !== (expect_err0 && c == 0)) begin
                errors++;
                $display("FAIL %s_c%0d: got data %h sb %b hdr %b err %b, expected 00000000 sb %b hdr 01 err %b",
                         name, c, descramblerDataOut, descramblerStartBlock, descramblerSyncHeader,
                         blockError, c == 0, expect_err0 && c == 0);
            end
        end
    endtask

    task automatic test_g3_data;
        apply_reset(3'd3, 6'd32);
        drive(1'b0, 32'h0, 4'h0, 2'b00, 1'b0);
        model = SEED;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, next_ks(), 4'h0, 2'b01, c == 0);
            checks++;
            if (descramblerDataOut !== 32'h0 || descramblerStartBlock !== (c == 0) || blockError !== 1'b0) begin
                errors++;
                $display("FAIL g3data_c%0d: got data %h sb %b err %b, expected 00000000 sb %b err 0",
                         c, descramblerDataOut, descramblerStartBlock, blockError, c == 0);
            end
            if (c == 1) begin
                drive(1'b0, 32'hDEADBEEF, 4'h0, 2'b01, 1'b0);
                checks++;
                if (descramblerDataOut !== 32'h0 || descramblerDataValid !== 1'b0) begin
                    errors++;
                    $display("FAIL g3_invalid: got data %h vld %b, expected 00000000 vld 0",
                             descramblerDataOut, descramblerDataValid);
                end
            end
        end
    endtask

    task automatic test_eieos;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 32'hFF00FF00, 4'h0, 2'b10, c == 0);
            checks++;
            if (descramblerDataOut !== 32'hFF00FF00 || descramblerSyncHeader !== 2'b10) begin
                errors++;
                $display("FAIL eieos_c%0d: got %h hdr %b, expected ff00ff00 hdr 10",
                         c, descramblerDataOut, descramblerSyncHeader);
            end
        end
        model = SEED;
        data_block("after_eieos", 1'b0);
    endtask

    task automatic test_bad_header;
        drive(1'b1, 32'h12345678, 4'h0, 2'b11, 1'b1);
        checks++;
        if (descramblerDataOut !== 32'h12345678 || blockError !== 1'b1) begin
            errors++;
            $display("FAIL badhdr: got %h err %b, expected 12345678 err 1", descramblerDataOut, blockError);
        end
        drive(1'b1, 32'hA5A5A5A5, 4'h0, 2'b01, 1'b0);
        checks++;
        if (descramblerDataOut !== 32'hA5A5A5A5 || blockError !== 1'b0) begin
            errors++;
            $display("FAIL syncwait_raw: got %h err %b, expected a5a5a5a5 err 0", descramblerDataOut, blockError);
        end
        data_block("after_badhdr", 1'b0);
    endtask

    task automatic test_restart;
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, next_ks(), 4'h0, 2'b01, c == 0);
            checks++;
            if (descramblerDataOut !== 32'h0 || blockError !== 1'b0) begin
                errors++;
                $display("FAIL partial_c%0d: got %h err %b, expected 00000000 err 0", c, descramblerDataOut, blockError);
            end
        end
        data_block("restart", 1'b1);
    endtask

    task automatic test_reset_mid;
        model = SEED;
        apply_reset(3'd3, 6'd32);
        drive(1'b0, 32'h0, 4'h0, 2'b00, 1'b0);
        drive(1'b1, 32'h11223344, 4'hF, 2'b01, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({descramblerDataOut, descramblerDataK, descramblerDataValid, descramblerSyncHeader,
             descramblerStartBlock, blockError} !== 41'b0) begin
            errors++;
            $display("FAIL reset_mid: got data %h k %b vld %b hdr %b sb %b err %b, expected all 0",
                     descramblerDataOut, descramblerDataK, descramblerDataValid,
                     descramblerSyncHeader, descramblerStartBlock, blockError);
        end
        @(posedge pclk);
        #1;
        reset = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 2'b00, 1'b0);
        data_block("post_reset", 1'b0);
    endtask

    initial begin
        test_reset();
        test_g12_w8();
        test_g12_w32();
        test_g3_data();
        test_eieos();
        test_bad_header();
        test_restart();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
